// File: rtl/bcd_xs3_seq_conv.sv
// Serial multi-digit BCD <-> Excess-3 converter with valid/ready handshakes.
// One digit is converted per clock, least significant digit first; every
// out-of-range digit is passed through unchanged and flagged in the mask.
module bcd_xs3_seq_conv #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_err,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  busy
);

    localparam int unsigned DW    = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned LAST  = DIGITS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      data_q, data_d;
    logic               mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DW-1:0]      res_q, res_d;
    logic [DIGITS-1:0]  mask_q, mask_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d;
    logic [3:0]         nib;
    logic [4:0]         cv;

    // Convert one nibble; returns {err, result}. Invalid digits pass through.
    function automatic logic [4:0] conv_nibble(input logic mode, input logic [3:0] n);
        logic [4:0] r;
        if (!mode) begin
            if (n <= 4'd9) r = {1'b0, 4'(n + 4'd3)};
            else           r = {1'b1, n};
        end else begin
            if ((n >= 4'd3) && (n <= 4'd12)) r = {1'b0, 4'(n - 4'd3)};
            else                             r = {1'b1, n};
        end
        return r;
    endfunction

    // Current digit selected by the serial index.
    always_comb begin
        nib = data_q[{idx_q, 2'b00} +: 4];
        cv  = conv_nibble(mode_q, nib);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        res_d   = res_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = in_mode;
                    idx_d   = '0;
                    mask_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                res_d[{idx_q, 2'b00} +: 4] = cv[3:0];
                mask_d[idx_q]              = cv[4];
                if (idx_q == IDX_W'(LAST)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        err_d = |mask_d;
    end

    // State and datapath registers; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    // Ready is held low during reset so no word can slip in on the reset edge.
    assign in_ready     = (state_q == IDLE) && !rst;
    assign busy         = (state_q != IDLE);
    assign out_valid    = valid_q;
    assign out_data     = res_q;
    assign out_err      = err_q;
    assign out_err_mask = mask_q;

endmodule

// File: tb/tb_bcd_xs3_seq_conv.sv
// Scoreboard bench for bcd_xs3_seq_conv with DIGITS=4.
module tb_bcd_xs3_seq_conv;

    localparam int DIGITS = 4;
    localparam int DW     = 4 * DIGITS;

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [DIGITS-1:0] mask;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              out_err;
    logic [DIGITS-1:0] out_err_mask;
    logic              busy;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    bcd_xs3_seq_conv #(.DIGITS(DIGITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err      (out_err),
        .out_err_mask (out_err_mask),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference digit rules.
    function automatic exp_t model(input logic m, input logic [DW-1:0] d);
        exp_t e;
        logic [3:0] n;
        for (int i = 0; i < DIGITS; i++) begin
            n = d[4*i +: 4];
            if (!m && n < 4'd10) begin
                e.data[4*i +: 4] = n + 4'd3;
                e.mask[i]        = 1'b0;
            end else if (m && n > 4'd2 && n < 4'd13) begin
                e.data[4*i +: 4] = n - 4'd3;
                e.mask[i]        = 1'b0;
            end else begin
                e.data[4*i +: 4] = n;
                e.mask[i]        = 1'b1;
            end
        end
        return e;
    endfunction

    // Send one word, check latency, result, optional DONE hold, and handshake.
    task automatic send_word(input logic m, input logic [DW-1:0] d, input bit early, input int hold);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 50) begin tick; cyc++; end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL accept_ready got=%b want=1", in_ready); end
        in_valid  = 1'b1;
        in_mode   = m;
        in_data   = d;
        out_ready = early;
        sb.push_back(model(m, d));
        tick;
        in_valid = 1'b0;
        in_data  = ~d;
        in_mode  = ~m;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            n_vec++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL conv_flags busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready);
            end
            tick;
            cyc++;
        end
        n_vec++;
        if (cyc != DIGITS) begin n_err++; $display("FAIL latency got=%0d want=%0d", cyc, DIGITS); end
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty got=0 want=1");
        end else begin
            e = sb.pop_front();
            if (out_data !== e.data || out_err_mask !== e.mask || out_err !== (|e.mask)) begin
                n_err++;
                $display("FAIL result data=%h mask=%b err=%b want data=%h mask=%b err=%b",
                         out_data, out_err_mask, out_err, e.data, e.mask, |e.mask);
            end
            for (int i = 0; i < hold; i++) begin
                out_ready = 1'b0;
                tick;
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== e.data || out_err_mask !== e.mask || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold valid=%b data=%h mask=%b in_ready=%b want 1 %h %b 0",
                             out_valid, out_data, out_err_mask, in_ready, e.data, e.mask);
                end
            end
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== e.data || out_err_mask !== e.mask) begin
                n_err++;
                $display("FAIL handshake valid=%b in_ready=%b busy=%b data=%h mask=%b want 0 1 0 %h %b",
                         out_valid, in_ready, busy, out_data, out_err_mask, e.data, e.mask);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
        tick; tick;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0 || out_err_mask !== '0 ||
            busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state valid=%b data=%h err=%b mask=%b busy=%b in_ready=%b want all 0",
                     out_valid, out_data, out_err, out_err_mask, busy, in_ready);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got=%b want=1", in_ready); end
        tick;
    endtask

    task automatic test_directed;
        send_word(1'b0, 16'h1234, 1'b0, 0);
        send_word(1'b1, 16'h4567, 1'b0, 0);
        send_word(1'b0, 16'h9A05, 1'b0, 0);
        send_word(1'b1, 16'h0003, 1'b0, 0);
        send_word(1'b1, 16'hFDC3, 1'b0, 0);
        send_word(1'b0, 16'hFFFF, 1'b0, 0);
    endtask

    task automatic test_hold;
        send_word(1'b0, 16'h1234, 1'b0, 5);
    endtask

    task automatic test_early_ready;
        send_word(1'b1, 16'hC93A, 1'b1, 0);
    endtask

    task automatic test_abort;
        int cyc;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 50) begin tick; cyc++; end
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h5678;
        tick;
        in_valid = 1'b0;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0 || out_err_mask !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state valid=%b data=%h err=%b mask=%b busy=%b want all 0",
                     out_valid, out_data, out_err, out_err_mask, busy);
        end
        for (int i = 0; i < 8; i++) begin
            tick;
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_valid got=%b want=0", out_valid); end
        end
        send_word(1'b0, 16'h0999, 1'b0, 0);
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] d;
        for (int i = 0; i < 10; i++) begin
            d = DW'($urandom);
            send_word(1'($urandom_range(0, 1)), d, 1'b0, 0);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_hold;
        test_early_ready;
        test_abort;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
